shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Command-level controller for the 16-bit universal PIPO shift register.
//  - Accepts {data, opcode, shift amount} commands on a valid/ready interface.
//  - Drives the register's load/shift_en/opcode pins to load the data, then
//    applies exactly 'amount' single-bit shifts.
//  - Returns the final register contents on a valid/ready response port.
//  - Sits between a requesting datapath/CPU-side block and one register instance.
// PARAMETERS
//  WIDTH  16  data width; must match the shift register (16)
//  CNT_W  5   shift-amount width; max amount = 2**CNT_W-1 (31)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      controller can accept a command
//  cmd_data     in   WIDTH  value to load
//  cmd_op       in   2      00 shl, 01 shr, 10 rotl, 11 rotr
//  cmd_amt      in   CNT_W  number of 1-bit shifts to apply
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer accepts result
//  rsp_data     out  WIDTH  result (= sr_data_out)
//  busy         out  1      high in any state other than IDLE
//  sr_load      out  1      to shift register load
//  sr_shift_en  out  1      to shift register shift_en
//  sr_opcode    out  2      to shift register opcode
//  sr_data_in   out  WIDTH  to shift register data_in
//  sr_data_out  in   WIDTH  from shift register data_out
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge):
//    - state<=IDLE; internal data/op/count registers <=0.
//    - While rst_n low, all outputs are 0, including cmd_ready.
//  - The shift register shares clk/rst_n with this block.
//    Reset mid-operation aborts the command: no response is issued.
//  - FSM is Moore; all outputs decode from registered state and regs.
//    - IDLE:  cmd_ready=1.
//             On cmd_valid&cmd_ready, capture data/op/amt and go to LOAD.
//    - LOAD:  one cycle. sr_load=1, sr_data_in=captured data.
//             Next state: SHIFT if amt!=0, else RESP.
//    - SHIFT: sr_shift_en=1, sr_opcode=captured op; counter loaded with amt.
//             Decrement the counter once per cycle. Leave on the cycle the
//             counter is 1 (exactly amt shift_en cycles), going to RESP.
//    - RESP:  rsp_valid=1, rsp_data=sr_data_out.
//             Hold until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
//  - Pin values outside the states above:
//    - sr_load=0 and sr_shift_en=0 in IDLE and RESP, so the register holds
//      rsp_data stable under backpressure.
//    - sr_opcode=captured op in all non-IDLE states; 0 in IDLE.
//    - sr_data_in=captured data in all states.
//  - Latency: command accepted at edge k -> rsp_valid high from cycle k+2+amt.
//  - cmd_ready=0 outside IDLE. No queuing; one command in flight.
//    A new command is accepted at the earliest in the cycle after the
//    response handshake (RESP->IDLE takes one edge).
//  - Shift semantics are the register's own:
//    - shl/shr are zero-fill; amt>=WIDTH yields 0.
//    - rotl/rotr are modulo WIDTH; amt=16 returns the original data.
//  - amt=0: LOAD then RESP; the result equals cmd_data.
//  - rsp_ready may be high before rsp_valid; this has no effect outside RESP.
//  - cmd_data/op/amt are don't-care when no handshake occurs.
// TESTING
//  1 Reset, then data=16'h8001, op=10, amt=1
//    -> one sr_shift_en cycle; rsp_data=16'h0003 at cycle k+3.
//  2 data=16'hF000, op=01, amt=4
//    -> exactly 4 shift_en cycles; rsp_data=16'h0F00.
//  3 data=16'hA5A5, op=11, amt=16 -> rsp_data=16'hA5A5.
//    Same data, op=00, amt=20 -> rsp_data=16'h0000.
//  4 data=16'h1234, amt=0 -> no shift_en; rsp_valid at cycle k+2;
//    rsp_data=16'h1234.
//  5 Hold rsp_ready=0 for 5 cycles in RESP
//    -> rsp_valid and rsp_data stable; cmd_ready=0 with cmd_valid held high;
//       next command accepted 1 cycle after the response handshake.
//  6 rst_n low for 1 cycle during SHIFT (amt=10)
//    -> outputs 0; FSM IDLE; sr_data_out=0; no rsp_valid;
//       cmd_ready=1 in the first cycle after rst_n returns high.

Source files
------------

// File: rtl/shift_sequencer.sv
// Command-level controller for a 16-bit universal PIPO shift register:
// loads a value, applies N single-bit shifts, and returns the result.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             sr_load,
    output logic             sr_shift_en,
    output logic [1:0]       sr_opcode,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            op_q    <= op_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        op_nxt    = op_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    data_nxt  = cmd_data;
                    op_nxt    = cmd_op;
                    cnt_nxt   = cmd_amt;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = (cnt_q != '0) ? SHIFT : RESP;
            end
            SHIFT: begin
                // Counter holds the shifts still to apply, including this cycle's.
                cnt_nxt = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is forced low while rst_n is held, independent of state.
    always_comb begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        busy        = 1'b0;
        sr_load     = 1'b0;
        sr_shift_en = 1'b0;
        sr_opcode   = 2'b00;
        sr_data_in  = '0;
        if (rst_n) begin
            cmd_ready   = (state_q == IDLE);
            busy        = (state_q != IDLE);
            sr_load     = (state_q == LOAD);
            sr_shift_en = (state_q == SHIFT);
            rsp_valid   = (state_q == RESP);
            sr_opcode   = (state_q != IDLE) ? op_q : 2'b00;
            sr_data_in  = data_q;
            rsp_data    = sr_data_out;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural shift register
// attached to its sr_* pins and an arithmetic reference for the results.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [1:0]       cmd_op = '0;
    logic [CNT_W-1:0] cmd_amt = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic             sr_load;
    logic             sr_shift_en;
    logic [1:0]       sr_opcode;
    logic [WIDTH-1:0] sr_data_in;
    logic [WIDTH-1:0] sr_data_out;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .sr_load(sr_load), .sr_shift_en(sr_shift_en),
        .sr_opcode(sr_opcode), .sr_data_in(sr_data_in), .sr_data_out(sr_data_out)
    );

    always #5 clk = ~clk;

    // Universal PIPO shift register the controller drives.
    always @(posedge clk) begin
        if (!rst_n)           sr_data_out <= '0;
        else if (sr_load)     sr_data_out <= sr_data_in;
        else if (sr_shift_en) begin
            case (sr_opcode)
                2'b00: sr_data_out <= {sr_data_out[WIDTH-2:0], 1'b0};
                2'b01: sr_data_out <= {1'b0, sr_data_out[WIDTH-1:1]};
                2'b10: sr_data_out <= {sr_data_out[WIDTH-2:0], sr_data_out[WIDTH-1]};
                default: sr_data_out <= {sr_data_out[0], sr_data_out[WIDTH-1:1]};
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op, input int amt);
        logic [31:0] w;
        int a;
        w = {16'h0, d};
        a = amt % WIDTH;
        case (op)
            2'b00: return (amt >= WIDTH) ? '0 : WIDTH'(w << amt);
            2'b01: return (amt >= WIDTH) ? '0 : WIDTH'(w >> amt);
            2'b10: return WIDTH'((w << a) | (w >> (WIDTH - a)));
            default: return WIDTH'((w >> a) | (w << (WIDTH - a)));
        endcase
    endfunction

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               amt;
        int               acc;
    } sb_t;
    sb_t sb[$];

    // 0: random rsp_ready, 1: held low, 2: held high
    int rdy_mode = 2;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: rsp_ready = ($urandom_range(0, 9) < 6);
                1: rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency, shift-cycle count, response stability and data.
    int               last_rsp_cyc = -1;
    int               shift_cnt = 0;
    bit               in_rsp = 0;
    logic [WIDTH-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp    = 0;
            shift_cnt = 0;
        end else begin
            if (sr_shift_en) shift_cnt++;
            if (rsp_valid && sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    chk("rsp_latency", 32'(cyc), 32'(sb[0].acc + 2 + sb[0].amt));
                    chk("shift_en_cycles", 32'(shift_cnt), 32'(sb[0].amt));
                    held   = rsp_data;
                    in_rsp = 1;
                end else begin
                    chk("rsp_data_stable", 32'(rsp_data), 32'(held));
                end
                chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
                if (rsp_ready) begin
                    chk("rsp_data", 32'(rsp_data), 32'(sb[0].exp));
                    void'(sb.pop_front());
                    in_rsp       = 0;
                    shift_cnt    = 0;
                    last_rsp_cyc = cyc;
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] op, input int amt,
                        input bit use_exp, input logic [WIDTH-1:0] exp, output int acc);
        sb_t e;
        bit  done;
        acc  = -1;
        done = 0;
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_op    = op;
        cmd_amt   = CNT_W'(amt);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                e.exp = use_exp ? exp : ref_result(d, op, amt);
                e.amt = amt;
                e.acc = cyc;
                sb.push_back(e);
                acc  = cyc;
                done = 1;
            end
        end
        if (!done) chk("cmd_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        cmd_data  = WIDTH'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {cmd_ready, rsp_valid, busy, sr_load, sr_shift_en, sr_opcode},
            32'd0);
        chk({name, "_data"}, {sr_data_in, rsp_data}, 32'd0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a, acc_b;
        bit seen;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Directed cases with fixed expected results.
        send(16'h8001, 2'b10, 1,  1, 16'h0003, acc_a);
        drain();
        send(16'hF000, 2'b01, 4,  1, 16'h0F00, acc_a);
        drain();
        send(16'hA5A5, 2'b11, 16, 1, 16'hA5A5, acc_a);
        drain();
        send(16'hA5A5, 2'b00, 20, 1, 16'h0000, acc_a);
        drain();
        send(16'h1234, 2'b01, 0,  1, 16'h1234, acc_a);
        drain();

        // Backpressure: response held 5 cycles while the next command waits.
        rdy_mode = 1;
        send(16'h00F0, 2'b00, 3, 1, 16'h0780, acc_a);
        fork
            send(16'h0101, 2'b10, 2, 1, 16'h0404, acc_b);
            begin
                seen = 0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                chk("rsp_valid_seen", 32'(seen), 32'd1);
                repeat (5) @(negedge clk);
                rdy_mode = 2;
            end
        join
        chk("accept_after_rsp", 32'(acc_b), 32'(last_rsp_cyc + 1));
        drain();

        // Reset during SHIFT aborts the command.
        send(16'hBEEF, 2'b10, 10, 1, 16'h0000, acc_a);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = sr_shift_en;
        end
        chk("shift_started", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_all_zero("mid_reset_outputs");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sr_data_out", 32'(sr_data_out), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (15) @(negedge clk);

        // Randomized traffic against the reference model.
        rdy_mode = 0;
        for (int n = 0; n < 80; n++) begin
            send(WIDTH'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 31),
                 0, '0, acc_a);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
